// File: rtl/wb_trace_pkg.sv
// ---------------------------------------------------------------------------
// wb_trace_pkg
// Shared widths, field offsets and the record layout for the writeback trace
// buffer.
//
// A trace record is packed MSB-first as {pc, ena, reg, value}:
//   pc    [69:38]
//   ena   [37]
//   reg   [36:32]
//   value [31:0]
// When WB_TRACE_SEQ_EN is defined, a 16-bit retire sequence number sits on top
// of the record in the stored and emitted word. That gives {seq[85:70], record[69:0]}.
// ---------------------------------------------------------------------------
package wb_trace_pkg;

  localparam int TR_PC_W  = 32;
  localparam int TR_REG_W = 5;
  localparam int TR_VAL_W = 32;
  localparam int TR_SEQ_W = 16;

  localparam int TR_REC_W = TR_PC_W + 1 + TR_REG_W + TR_VAL_W;  // 70

  // Field offsets inside a record word.
  localparam int TR_VAL_LSB = 0;
  localparam int TR_REG_LSB = TR_VAL_LSB + TR_VAL_W;            // 32
  localparam int TR_ENA_BIT = TR_REG_LSB + TR_REG_W;            // 37
  localparam int TR_PC_LSB  = TR_ENA_BIT + 1;                   // 38

`ifdef WB_TRACE_SEQ_EN
  localparam int TR_SEQ_LSB = TR_REC_W;                         // 70
  localparam int TR_OUT_W   = TR_REC_W + TR_SEQ_W;              // 86
`else
  localparam int TR_OUT_W   = TR_REC_W;                         // 70
`endif

  // One retired instruction as seen on the core's writeback debug port.
  typedef struct packed {
    logic [TR_PC_W-1:0]  pc;
    logic                ena;
    logic [TR_REG_W-1:0] rd;
    logic [TR_VAL_W-1:0] value;
  } tr_rec_t;

  // Flatten a record into its bit layout using the named offsets, so the
  // layout has one authoritative definition.
  function automatic logic [TR_REC_W-1:0] tr_pack(input tr_rec_t rec);
    logic [TR_REC_W-1:0] w;
    w = '0;
    w[TR_PC_LSB  +: TR_PC_W]  = rec.pc;
    w[TR_ENA_BIT]             = rec.ena;
    w[TR_REG_LSB +: TR_REG_W] = rec.rd;
    w[TR_VAL_LSB +: TR_VAL_W] = rec.value;
    return w;
  endfunction

endpackage

// File: rtl/wb_trace_ram.sv
// ---------------------------------------------------------------------------
// wb_trace_ram
// DEPTH x W register array that holds the trace FIFO storage. It has one
// synchronous write port and one asynchronous read port. The read port feeds
// the head record straight to the stream output, which makes the FIFO
// show-ahead.
//
// The storage has no reset. The parent never presents a slot that has not
// been written, because it masks the read data while the FIFO is empty.
//
// Ports
//   clk      in   1      write clock
//   i_we     in   1      write enable
//   i_waddr  in   AW     write address
//   i_wdata  in   W      write data
//   i_raddr  in   AW     read address (async)
//   o_rdata  out  W      read data
// ---------------------------------------------------------------------------
module wb_trace_ram #(
  parameter  int DEPTH = 16,
  parameter  int W     = 70,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// ---------------------------------------------------------------------------
// wb_trace_buffer
// Captures one trace record per retired instruction from the core's
// writeback debug port into a show-ahead FIFO. It drains the records over a
// valid/ready stream. When the FIFO is full and the sink does not take the
// head, an incoming record is dropped. The drop is recorded: the sticky
// overflow flag is set and a saturating drop counter increments.
//
// Build option: define WB_TRACE_SEQ_EN to add a 16-bit retire sequence
// counter. The counter is stored with every entry and sent as the top 16
// bits of tr_data. It advances on every retire strobe, including dropped
// ones, so the sink can find losses from gaps in the sequence.
//
// Stream handshake: a record transfers on a rising edge where
// tr_valid && tr_ready. While tr_valid is high and tr_ready is low, tr_data
// holds stable. tr_valid falls only after a transfer or a flush. tr_data is
// zero whenever tr_valid is low.
//
// Ports
//   clk           in   1              clock, all state on posedge
//   rst           in   1              async active-high reset
//   flush         in   1              sync clear of contents and overflow
//   wb_have_inst  in   1              retire strobe
//   wb_pc         in   32             retired PC
//   wb_ena        in   1              regfile write enable of the retiree
//   wb_reg        in   5              destination register
//   wb_value      in   32             writeback value
//   tr_valid      out  1              head record available
//   tr_ready      in   1              sink accepts head record
//   tr_data       out  TR_OUT_W       head record (70 or 86 bits)
//   level         out  log2(DEPTH)+1  occupancy
//   overflow      out  1              sticky drop flag
//   drop_cnt      out  DROP_W         saturating drop count
// ---------------------------------------------------------------------------
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter  int DEPTH  = 16,   // power of two, >= 2
  parameter  int DROP_W = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                wb_have_inst,
  input  logic [TR_PC_W-1:0]  wb_pc,
  input  logic                wb_ena,
  input  logic [TR_REG_W-1:0] wb_reg,
  input  logic [TR_VAL_W-1:0] wb_value,
  output logic                tr_valid,
  input  logic                tr_ready,
  output logic [TR_OUT_W-1:0] tr_data,
  output logic [LVL_W-1:0]    level,
  output logic                overflow,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_overflow;
  logic [DROP_W-1:0]   r_drop_cnt;

  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  tr_rec_t             w_rec;
  logic [TR_OUT_W-1:0] w_wr_data;
  logic [TR_OUT_W-1:0] w_rd_data;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LVL);

  // A pop frees a slot in the same edge. This lets a full FIFO accept a
  // push alongside a pop. Flush overrides both and also discards the
  // strobe without counting it as a drop.
  assign w_pop  = !w_empty && tr_ready && !flush;
  assign w_push = wb_have_inst && !flush && (!w_full || w_pop);
  assign w_drop = wb_have_inst && !flush && w_full && !w_pop;

  // -------------------------------------------------------------------------
  // Record assembly
  // -------------------------------------------------------------------------
  always_comb begin
    w_rec       = '0;
    w_rec.pc    = wb_pc;
    w_rec.ena   = wb_ena;
    w_rec.rd    = wb_reg;
    w_rec.value = wb_value;
  end

`ifdef WB_TRACE_SEQ_EN
  logic [TR_SEQ_W-1:0] r_seq;

  // The counter advances on every retire strobe, whether the record is
  // captured or dropped, and wraps naturally at 0xFFFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seq <= '0;
    end else if (wb_have_inst) begin
      r_seq <= r_seq + TR_SEQ_W'(1);
    end
  end

  assign w_wr_data = {r_seq, tr_pack(w_rec)};
`else
  assign w_wr_data = tr_pack(w_rec);
`endif

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  wb_trace_ram #(
    .DEPTH (DEPTH),
    .W     (TR_OUT_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (w_wr_data),
    .i_raddr (r_rptr),
    .o_rdata (w_rd_data)
  );

  // -------------------------------------------------------------------------
  // Pointers, occupancy, overflow flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Only reset clears the drop counter. It survives a flush so that losses
  // stay visible across harness-initiated clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + DROP_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // tr_valid comes only from registered occupancy. A record written on an
  // edge therefore appears on the following cycle and is never bypassed.
  assign tr_valid = !w_empty;
  assign tr_data  = tr_valid ? w_rd_data : '0;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule
